// File: rtl/ls7404.sv
// Hex inverter with a combinational output, a registered output and a saturating
// toggle counter. Define LS7404_FAULT_INJ_EN to add per-bit forcing of the registered path.
module ls7404 #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    input  logic             cnt_clr,
`ifdef LS7404_FAULT_INJ_EN
    input  logic [WIDTH-1:0] fault_mask,
    input  logic [WIDTH-1:0] fault_val,
`endif
    output logic [CNT_W-1:0] toggle_cnt,
    output logic             toggle_sat
);

    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] out_d, out_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    // Each gate is built independently so bit i only ever sees a[i].
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_gate
        assign y[gi] = ~a[gi];
`ifdef LS7404_FAULT_INJ_EN
        assign load_val[gi] = fault_mask[gi] ? fault_val[gi] : ~a[gi];
`else
        assign load_val[gi] = ~a[gi];
`endif
    end

    always_comb begin
        out_d = load_val;
        cnt_d = cnt_q;
        // Clear beats increment; a change in any number of bits is one toggle.
        if (cnt_clr) begin
            cnt_d = '0;
        end else if ((load_val != out_q) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= {WIDTH{1'b1}};
            cnt_q <= '0;
        end else begin
            out_q <= out_d;
            cnt_q <= cnt_d;
        end
    end

    assign y_q        = out_q;
    assign toggle_cnt = cnt_q;
    assign toggle_sat = (cnt_q == {CNT_W{1'b1}});

endmodule

// File: tb/tb_ls7404.sv
// Directed self-checking bench for ls7404 (CNT_W=4 so saturation is reachable quickly).
module tb_ls7404;

    localparam int WIDTH = 6;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             clk_run = 1'b0;
    logic             rst = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] y_q;
    logic             cnt_clr = 1'b0;
    logic [CNT_W-1:0] toggle_cnt;
    logic             toggle_sat;
`ifdef LS7404_FAULT_INJ_EN
    logic [WIDTH-1:0] fault_mask = '0;
    logic [WIDTH-1:0] fault_val = '0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    ls7404 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .a          (a),
        .y          (y),
        .y_q        (y_q),
        .cnt_clr    (cnt_clr),
`ifdef LS7404_FAULT_INJ_EN
        .fault_mask (fault_mask),
        .fault_val  (fault_val),
`endif
        .toggle_cnt (toggle_cnt),
        .toggle_sat (toggle_sat)
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [WIDTH-1:0] exp6;

        // Combinational path with the clock stopped
        a = 6'b001010; #10;
        check("y_ex1", 32'(y), 32'(6'b110101));
        a = 6'b000101; #10;
        check("y_ex2", 32'(y), 32'(6'b111010));
        for (int i = 0; i < 64; i++) begin
            a = 6'(i);
            exp6 = 6'b111111 ^ 6'(i);
            #2;
            check($sformatf("y_sweep_%0d", i), 32'(y), 32'(exp6));
        end

        // Start clock, reset, hold zeros
        clk_run = 1'b1;
        rst = 1'b1; a = 6'b000000;
        tick();
        rst = 1'b0;
        check("rst_yq", 32'(y_q), 32'(6'b111111));
        check("rst_cnt", 32'(toggle_cnt), 32'd0);
        check("rst_sat", 32'(toggle_sat), 32'd0);
        tick(); tick(); tick();
        check("hold0_yq", 32'(y_q), 32'(6'b111111));
        check("hold0_cnt", 32'(toggle_cnt), 32'd0);
        a = 6'b111111;
        tick();
        check("all_flip_yq", 32'(y_q), 32'(6'b000000));
        check("all_flip_cnt", 32'(toggle_cnt), 32'd1);

        // Saturation: 20 toggles from count 1 must stop at 15
        for (int i = 0; i < 20; i++) begin
            a = ~a;
            tick();
        end
        check("sat_cnt", 32'(toggle_cnt), 32'd15);
        check("sat_flag", 32'(toggle_sat), 32'd1);
        check("sat_yq", 32'(y_q), 32'(6'b000000));

        // Clear wins over a simultaneous toggle; y_q still loads
        cnt_clr = 1'b1; a = 6'b101100;
        tick();
        cnt_clr = 1'b0;
        check("clr_cnt", 32'(toggle_cnt), 32'd0);
        check("clr_sat", 32'(toggle_sat), 32'd0);
        check("clr_yq", 32'(y_q), 32'(6'b010011));
        tick();
        check("noTog_cnt", 32'(toggle_cnt), 32'd0);
        a = 6'b101101;
        tick();
        check("oneBit_cnt", 32'(toggle_cnt), 32'd1);
        check("oneBit_yq", 32'(y_q), 32'(6'b010010));

        // Reset mid-operation while a keeps toggling
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = (i % 2 == 0) ? 6'b110010 : 6'b001101;
            exp6 = (i % 2 == 0) ? 6'b001101 : 6'b110010;
            #1;
            check($sformatf("rstop_y_%0d", i), 32'(y), 32'(exp6));
            tick();
            check($sformatf("rstop_yq_%0d", i), 32'(y_q), 32'(6'b111111));
            check($sformatf("rstop_cnt_%0d", i), 32'(toggle_cnt), 32'd0);
        end
        rst = 1'b0; a = 6'b000011;
        tick();
        check("post_rst_yq", 32'(y_q), 32'(6'b111100));
        check("post_rst_cnt", 32'(toggle_cnt), 32'd1);

`ifdef LS7404_FAULT_INJ_EN
        a = 6'b000000; fault_mask = 6'b000001; fault_val = 6'b000000;
        tick();
        check("fault_yq", 32'(y_q), 32'(6'b111110));
        check("fault_y", 32'(y), 32'(6'b111111));
        check("fault_cnt", 32'(toggle_cnt), 32'd2);
        fault_mask = 6'b000000;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ls7404.md
LS7404 -- requirements
Module: ls7404

Interface
REQ-001 Parameter: WIDTH, default 6, number of independent inverter gates; the only supported value is 6.
REQ-002 Parameter: CNT_W, default 16, width of toggle counter; legal range 4..32.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: a  input  WIDTH  gate inputs, bit i drives gate i.
REQ-006 Port: y  output  WIDTH  combinational inverter outputs.
REQ-007 Port: y_q  output  WIDTH  registered inverter outputs.
REQ-008 Port: cnt_clr  input  1  synchronous clear of toggle counter.
REQ-009 Port: toggle_cnt  output  CNT_W  count of cycles in which y_q changed.
REQ-010 Port: toggle_sat  output  1  high while toggle_cnt is at all-ones.

Function
REQ-011 y SHALL equal bitwise NOT of a at all times, purely combinational, zero clock latency.
REQ-012 y SHALL NOT depend on clk, rst, cnt_clr or any internal state; it is valid with clk idle and rst never asserted.
REQ-013 Example: a=6'b001010 gives y=6'b110101; a=6'b000101 gives y=6'b111010.
REQ-014 Each gate i SHALL be independent: y[i] depends only on a[i].
REQ-015 y_q SHALL load ~a on every rising clk edge when rst is low; latency exactly one cycle.
REQ-016 A cycle counts as a toggle when the value being loaded into y_q differs from the current y_q in at least one bit.
REQ-017 On a toggle cycle toggle_cnt SHALL increment by one, saturating at all-ones; it never wraps to zero.
REQ-018 toggle_sat SHALL be combinationally high exactly when toggle_cnt is all-ones.
REQ-019 cnt_clr high at an edge SHALL set toggle_cnt to zero, taking priority over a simultaneous toggle increment; y_q still updates.
REQ-020 Multiple bits changing in one cycle SHALL count as a single toggle.

Reset
REQ-021 rst high at a rising edge SHALL set y_q to all-ones (inverse of all-zero inputs) and toggle_cnt to zero.
REQ-022 rst SHALL take priority over cnt_clr and over the y_q load; the reset edge is not a toggle.
REQ-023 Asserting rst mid-operation SHALL NOT disturb y; the first edge after rst deasserts loads ~a and counts a toggle if it differs from all-ones.

Configuration
REQ-024 Macro LS7404_FAULT_INJ_EN, when defined, SHALL add input ports fault_mask (WIDTH) and fault_val (WIDTH).
REQ-025 With LS7404_FAULT_INJ_EN defined, the value loaded into y_q bit i SHALL be fault_val[i] when fault_mask[i] is high, else ~a[i]; toggle detection uses this forced value.
REQ-026 Fault injection SHALL NEVER affect y; y remains ~a.
REQ-027 Without LS7404_FAULT_INJ_EN the fault ports SHALL NOT exist and y_q behaves per REQ-015.

Verification
REQ-028 No clock, a=6'b001010, wait 10 ns -> y=6'b110101; a=6'b000101, wait 10 ns -> y=6'b111010.
REQ-029 Sweep a through all 64 values with clock stopped -> y==~a for each value.
REQ-030 rst one cycle, then a=6'b000000 held 3 cycles -> y_q=6'b111111, toggle_cnt=0; then a=6'b111111 -> next edge y_q=6'b000000, toggle_cnt=1.
REQ-031 CNT_W=4, toggle a every cycle for 20 cycles -> toggle_cnt stops at 15, toggle_sat=1; cnt_clr with toggle -> toggle_cnt=0.
REQ-032 rst asserted while a toggles -> y tracks ~a unchanged, y_q=6'b111111, toggle_cnt=0.
REQ-033 With LS7404_FAULT_INJ_EN, fault_mask=6'b000001, fault_val=0, a=0 -> y_q=6'b111110, y=6'b111111.
